// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch pin and debounced level/edge outputs
interface switch_debouncer_if;
    logic i_Switch;
    logic o_Debounced;
    logic o_Rise;
    logic o_Fall;

    modport master (output i_Switch, input o_Debounced, o_Rise, o_Fall);
    modport slave (input i_Switch, output o_Debounced, o_Rise, o_Fall);
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronised, FSM-filtered switch level with rise/fall pulses; SWITCH_DEBOUNCER_REPEAT_EN adds auto-repeat on o_Rise
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic        INIT_LEVEL     = 1'b0,
    parameter int unsigned REPEAT_DELAY   = 12500000,
    parameter int unsigned REPEAT_PERIOD  = 2500000
) (
    input logic               i_Clk,
    input logic               i_Reset,
    switch_debouncer_if.slave sw
);
    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
    localparam bit INSTANT = DEBOUNCE_LIMIT == 1;

    typedef enum logic [1:0] {STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW} state_t;
    localparam state_t INIT_STATE = INIT_LEVEL ? STABLE_HIGH : STABLE_LOW;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   deb_q, deb_d, rise_q, rise_d, fall_q, fall_d;
    logic                   s, rep_hit;

    assign s              = sync_q[SYNC_STAGES-1];
    assign sw.o_Debounced = deb_q;
    assign sw.o_Rise      = rise_q;
    assign sw.o_Fall      = fall_q;

    // bring the asynchronous pin into the clock domain
    always_ff @(posedge i_Clk or posedge i_Reset)
        if (i_Reset) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], sw.i_Switch};

    // FSM state, stability counter and registered outputs
    always_ff @(posedge i_Clk or posedge i_Reset)
        if (i_Reset) begin
            state_q <= INIT_STATE;
            cnt_q   <= '0;
            deb_q   <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end

    // a new level is accepted only after LIMIT consecutive mismatching samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LOW: if (s) begin
                state_d = INSTANT ? STABLE_HIGH : PEND_HIGH;
                cnt_d   = INSTANT ? '0 : CW'(1);
            end
            PEND_HIGH: begin
                state_d = !s ? STABLE_LOW : (cnt_q == LAST ? STABLE_HIGH : PEND_HIGH);
                cnt_d   = (!s || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
            STABLE_HIGH: if (!s) begin
                state_d = INSTANT ? STABLE_LOW : PEND_LOW;
                cnt_d   = INSTANT ? '0 : CW'(1);
            end
            PEND_LOW: begin
                state_d = s ? STABLE_HIGH : (cnt_q == LAST ? STABLE_LOW : PEND_LOW);
                cnt_d   = (s || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
        endcase
    end

    // level follows the accepting states; pulses mark the edge on which it changes
    always_comb begin
        deb_d  = state_d == STABLE_HIGH || state_d == PEND_LOW;
        rise_d = (deb_d & ~deb_q) | rep_hit;
        fall_d = ~deb_d & deb_q;
    end

`ifdef SWITCH_DEBOUNCER_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] AGAIN = RW'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [RW-1:0] rep_q, rep_d, rep_nxt;
    logic          held;

    assign held    = deb_q & deb_d;
    assign rep_nxt = rep_q + RW'(1);

    // edges since the accepted rise, folded back to DELAY after each period so it stays bounded
    always_comb begin
        rep_hit = held && (rep_nxt == FIRST || rep_nxt == AGAIN);
        rep_d   = !held ? '0 : (rep_nxt == AGAIN ? FIRST : rep_nxt);
    end

    // repeat counter register, cleared whenever the level is low or falling
    always_ff @(posedge i_Clk or posedge i_Reset)
        if (i_Reset) rep_q <= '0;
        else         rep_q <= rep_d;
`else
    logic unused_rep;

    assign rep_hit    = 1'b0;
    assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random stimulus checked against a sample-window reference model
module tb_switch_debouncer;
    localparam int LIMIT  = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;
`ifdef SWITCH_DEBOUNCER_REPEAT_EN
    localparam int HELD_RISES = 5;
`else
    localparam int HELD_RISES = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_v = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    bit   m_sync[$];
    bit   m_pend[$];
    bit   m_lvl, m_rise, m_fall;
    int   m_rep;

    switch_debouncer_if bus ();

    switch_debouncer #(
        .DEBOUNCE_LIMIT(LIMIT),
        .SYNC_STAGES(2),
        .INIT_LEVEL(1'b0),
        .REPEAT_DELAY(DELAY),
        .REPEAT_PERIOD(PERIOD)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .sw(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl  = 1'b0;
        m_sync = '{1'b0, 1'b0};
        m_pend.delete();
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_rep  = 0;
    endtask

    task automatic model_edge(input bit sample);
        bit s, acc;
        if (rst) model_reset();
        else begin
            s = m_sync.pop_front();
            m_sync.push_back(sample);
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_pend.push_back(s);
            if (m_pend.size() > LIMIT) void'(m_pend.pop_front());
            acc = m_pend.size() == LIMIT;
            foreach (m_pend[i]) if (m_pend[i] == m_lvl) acc = 1'b0;
            if (acc) begin
                m_lvl = !m_lvl;
                m_pend.delete();
                m_rise = m_lvl;
                m_fall = !m_lvl;
                m_rep  = 0;
            end else if (m_lvl) begin
                m_rep++;
`ifdef SWITCH_DEBOUNCER_REPEAT_EN
                m_rise = m_rep >= DELAY && (m_rep - DELAY) % PERIOD == 0;
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(sw_v);
        #1;
        check("level", bus.o_Debounced, m_lvl);
        check("rise", bus.o_Rise, m_rise);
        check("fall", bus.o_Fall, m_fall);
        check("rise_fall_excl", bus.o_Rise & bus.o_Fall, 0);
    endtask

    task automatic set_sw(input logic v);
        sw_v = v;
        bus.i_Switch = v;
    endtask

    task automatic run(input int n, output int fr, output int ff, output int nr, output int nf);
        fr = -1; ff = -1; nr = 0; nf = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.o_Rise) begin nr++; if (fr < 0) fr = i; end
            if (bus.o_Fall) begin nf++; if (ff < 0) ff = i; end
        end
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_level", bus.o_Debounced, 0);
        check("async_rst_rise", bus.o_Rise, 0);
        check("async_rst_fall", bus.o_Fall, 0);
    endtask

    initial begin
        int fr, ff, nr, nf;
        set_sw(1'b0);
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        run(2, fr, ff, nr, nf);
        check("reset_quiet_pulses", nr + nf, 0);

        set_sw(1'b1);
        run(10, fr, ff, nr, nf);
        check("step_rise_edge", fr, 6);
        check("step_rise_count", nr, 1);
        set_sw(1'b0);
        run(10, fr, ff, nr, nf);
        check("step_fall_edge", ff, 6);
        check("step_fall_count", nf, 1);

        set_sw(1'b1);
        run(10, fr, ff, nr, nf);
        check("pre_reset_level", bus.o_Debounced, 1);
        async_reset();
        run(3, fr, ff, nr, nf);
        check("rise_during_reset", nr, 0);
        rst = 1'b0;
        run(10, fr, ff, nr, nf);
        check("post_reset_rise_edge", fr, 6);
        check("post_reset_rise_count", nr, 1);

        set_sw(1'b0);
        run(10, fr, ff, nr, nf);
        set_sw(1'b1);
        run(3, fr, ff, nr, nf);
        check("bounce_run_rise", nr, 0);
        set_sw(1'b0);
        tick();
        set_sw(1'b1);
        run(10, fr, ff, nr, nf);
        check("bounce_rise_edge", fr, 6);
        check("bounce_rise_count", nr, 1);

        set_sw(1'b0);
        tick();
        set_sw(1'b1);
        run(10, fr, ff, nr, nf);
        check("glitch_fall_count", nf, 0);
        check("glitch_level", bus.o_Debounced, 1);

        set_sw(1'b0);
        run(10, fr, ff, nr, nf);
        set_sw(1'b1);
        run(4, fr, ff, nr, nf);
        async_reset();
        tick();
        rst = 1'b0;
        run(10, fr, ff, nr, nf);
        check("midcount_reset_rise_edge", fr, 6);

        set_sw(1'b0);
        run(10, fr, ff, nr, nf);
        set_sw(1'b1);
        run(50, fr, ff, nr, nf);
        check("held_first_rise", fr, 6);
        check("held_rise_count", nr, HELD_RISES);
        set_sw(1'b0);
        run(12, fr, ff, nr, nf);
        check("release_fall_edge", ff, 6);
        check("release_fall_count", nf, 1);
        check("release_rise_count", nr, 0);

        for (int seg = 0; seg < 80; seg++) begin
            set_sw(1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 7)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
